// File: rtl/vga_scanout.sv
// Raster timing, vram_vga prefetch (4-deep FIFO) and 1-bit pixel serialiser for the monochrome console.
// Optional VGA_UNDERRUN_MARK_EN: starved words show as a 0101... stripe instead of black.
module vga_scanout #(
  parameter int H_ACTIVE = 768,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 896,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 30
) (
  input  logic        clk,
  input  logic        reset,
  output logic [14:0] vram_vga_addr,
  output logic        vram_vga_req,
  input  logic        vram_vga_ready,
  input  logic [31:0] vram_vga_data_out,
  output logic        vga_pixel,
  output logic        vga_hsync_n,
  output logic        vga_vsync_n,
  output logic        vga_blank,
  output logic        underrun
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FW      = (H_ACTIVE / 32) * V_ACTIVE;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [14:0]   FW_C   = 15'(FW);

`ifdef VGA_UNDERRUN_MARK_EN
  localparam logic [31:0] FILL = 32'hAAAA_AAAA;
`else
  localparam logic [31:0] FILL = 32'h0;
`endif

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [31:0]   fifo [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    count, count_nx;
  logic [14:0]   addr_nx;
  logic [31:0]   shreg, word;
  logic          h_wrap, v_wrap, active, hsync, vsync, rewind;
  logic          accept, push, pop, pop_ok, req_nx;

  always_comb begin
    h_wrap  = (h_cnt == H_LAST);
    v_wrap  = (v_cnt == V_LAST);
    active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hsync   = (h_cnt >= H_SS) && (h_cnt < H_SE);
    vsync   = (v_cnt >= V_SS) && (v_cnt < V_SE);
    rewind  = (v_cnt == V_ACT) && (h_cnt == '0);
    accept  = vram_vga_req && vram_vga_ready;
    // flush wins over a word arriving in the rewind cycle
    push    = accept && !rewind;
    pop     = active && (h_cnt[4:0] == 5'd0);
    pop_ok  = pop && (count != 3'd0);
    word    = pop_ok ? fifo[rd_ptr] : FILL;
    count_nx = rewind ? 3'd0 : count + {2'b0, push} - {2'b0, pop_ok};
    addr_nx  = rewind ? 15'd0 : vram_vga_addr + {14'b0, accept};
    // request is registered, so it is decided from next-cycle occupancy and address
    req_nx   = (count_nx < 3'd4) && (addr_nx < FW_C);
  end

  always_ff @(posedge clk) begin
    if (push && !reset) fifo[wr_ptr] <= vram_vga_data_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      shreg         <= '0;
      vram_vga_addr <= '0;
      vram_vga_req  <= 1'b0;
      vga_pixel     <= 1'b0;
      vga_hsync_n   <= 1'b1;
      vga_vsync_n   <= 1'b1;
      vga_blank     <= 1'b1;
      underrun      <= 1'b0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;

      if (rewind) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      end
      count         <= count_nx;
      vram_vga_addr <= addr_nx;
      vram_vga_req  <= req_nx;

      // bit 0 of a freshly popped word is emitted in the same cycle as the load
      if (pop) begin
        shreg     <= word >> 1;
        vga_pixel <= word[0];
      end else begin
        shreg     <= shreg >> 1;
        vga_pixel <= active & shreg[0];
      end
      if (pop && (count == 3'd0)) underrun <= 1'b1;

      vga_hsync_n <= !hsync;
      vga_vsync_n <= !vsync;
      vga_blank   <= !active;
    end
  end
endmodule

// File: tb/tb_vga_scanout.sv
// Scaled-down raster (64x6 visible) exercising timing, prefetch, rewind, starvation and mid-line reset.
module tb_vga_scanout;
  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int WPL = HA / 32;
  localparam int FW = WPL * VA;
`ifdef VGA_UNDERRUN_MARK_EN
  localparam logic [31:0] FILL = 32'hAAAA_AAAA;
`else
  localparam logic [31:0] FILL = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] vram_vga_addr;
  logic        vram_vga_req;
  logic        vram_vga_ready;
  logic [31:0] vram_vga_data_out;
  logic        vga_pixel, vga_hsync_n, vga_vsync_n, vga_blank, underrun;

  vga_scanout #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
    .clk(clk), .reset(reset),
    .vram_vga_addr(vram_vga_addr), .vram_vga_req(vram_vga_req),
    .vram_vga_ready(vram_vga_ready), .vram_vga_data_out(vram_vga_data_out),
    .vga_pixel(vga_pixel), .vga_hsync_n(vga_hsync_n), .vga_vsync_n(vga_vsync_n),
    .vga_blank(vga_blank), .underrun(underrun));

  always #5 clk = ~clk;

  // frame buffer holds word N at address N
  assign vram_vga_data_out = {17'd0, vram_vga_addr};

  int passed = 0, total = 0;
  int mode = 0;  // 0: ready always, 1: ready 1-in-3, 2: ready never
  int rcyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] exp_word(input int s, input int f, input int md);
    if (md == 2) return FILL;
    if (f == 0) return (s == 0) ? FILL : 32'(s - 1);
    return 32'(s);
  endfunction

  // model state: (mh,mv) position of the coming cycle, (ph,pv,pf) position shown on outputs
  int mh = 0, mv = 0, fidx = 0, ph = 0, pv = 0, pf = 0;
  bit pvalid = 0, after_rst = 0, flushed = 0;
  int exp_addr = 0, acc_cnt = 0, blk_cnt = 0, hs_cnt = 0, vs_cnt = 0;
  logic [63:0] cap0, cap1;

  always @(negedge clk) begin
    if (after_rst) begin
      chk("rst_pixel", 64'(vga_pixel), 64'd0);
      chk("rst_hsync_n", 64'(vga_hsync_n), 64'd1);
      chk("rst_vsync_n", 64'(vga_vsync_n), 64'd1);
      chk("rst_blank", 64'(vga_blank), 64'd1);
      chk("rst_underrun", 64'(underrun), 64'd0);
      chk("rst_req", 64'(vram_vga_req), 64'd0);
      chk("rst_addr", 64'(vram_vga_addr), 64'd0);
    end else if (pvalid) begin
      bit act, ehs, evs, epix;
      logic [31:0] w;
      act  = (ph < HA) && (pv < VA);
      ehs  = (ph >= HA + HF) && (ph < HA + HF + HS);
      evs  = (pv >= VA + VF) && (pv < VA + VF + VS);
      epix = 1'b0;
      if (act) begin
        w = exp_word(pv * WPL + ph / 32, pf, mode);
        epix = w[ph % 32];
      end
      chk("pixel", 64'(vga_pixel), 64'(epix));
      chk("blank", 64'(vga_blank), 64'(!act));
      chk("hsync_n", 64'(vga_hsync_n), 64'(!ehs));
      chk("vsync_n", 64'(vga_vsync_n), 64'(!evs));
      // the pop at (0,0) right after reset always finds the FIFO empty
      chk("underrun", 64'(underrun), 64'd1);
      if (!vga_blank) blk_cnt++;
      if (!vga_hsync_n) hs_cnt++;
      if (!vga_vsync_n) vs_cnt++;
      if (ph == HT - 1 && pv == VT - 1) begin
        chk("frame_blank_low", 64'(blk_cnt), 64'd384);
        chk("frame_hsync_low", 64'(hs_cnt), 64'd88);
        chk("frame_vsync_low", 64'(vs_cnt), 64'd160);
        blk_cnt = 0; hs_cnt = 0; vs_cnt = 0;
      end
      if (pf == 1 && mode != 2 && ph < 64) begin
        if (pv == 0) cap0[ph] = vga_pixel;
        if (pv == 1) cap1[ph] = vga_pixel;
        if (pv == 1 && ph == 63) begin
          chk("line0_words01", cap0, 64'h0000_0001_0000_0000);
          chk("line1_words23", cap1, 64'h0000_0003_0000_0002);
        end
      end
    end

    if (reset) begin
      after_rst = 1; pvalid = 0; mh = 0; mv = 0; fidx = 0;
      exp_addr = 0; flushed = 0; acc_cnt = 0;
      blk_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    end else begin
      chk("addr", 64'(vram_vga_addr), 64'(exp_addr));
      if (exp_addr >= FW) chk("req_low_at_end", 64'(vram_vga_req), 64'd0);
      if (mode == 2 && !after_rst) chk("req_starved", 64'(vram_vga_req), 64'd1);
      if (mh == 0 && mv == 0 && flushed) begin
        if (mode != 2) chk("prefetch_words", 64'(acc_cnt), 64'd4);
        flushed = 0;
      end
      if (vram_vga_req && vram_vga_ready) begin
        exp_addr++;
        if (flushed) acc_cnt++;
      end
      if (mh == 0 && mv == VA) begin
        exp_addr = 0; flushed = 1; acc_cnt = 0;
      end
      ph = mh; pv = mv; pf = fidx; pvalid = 1; after_rst = 0;
      if (mh == HT - 1) begin
        mh = 0;
        if (mv == VT - 1) begin mv = 0; fidx++; end
        else mv++;
      end else mh++;
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      rcyc++;
      case (mode)
        0:       vram_vga_ready = 1'b1;
        1:       vram_vga_ready = (rcyc % 3 == 0);
        default: vram_vga_ready = 1'b0;
      endcase
    end
  endtask

  task automatic wait_pos(input int h, input int v);
    int n = 0;
    while (!(mh == h && mv == v) && n < 2 * HT * VT) begin run(1); n++; end
    total++;
    if (mh == h && mv == v) passed++;
    else $display("FAIL wait_pos: got h=%0d v=%0d expected h=%0d v=%0d", mh, mv, h, v);
  endtask

  initial begin
    reset = 1'b1; vram_vga_ready = 1'b0; mode = 0;
    run(3); reset = 1'b0;
    run(2 * HT * VT + 200);
    wait_pos(40, 1);
    reset = 1'b1; run(1); reset = 1'b0;
    run(HT * VT + 100);
    mode = 1; reset = 1'b1; run(2); reset = 1'b0;
    run(2 * HT * VT + 200);
    mode = 2; reset = 1'b1; run(2); reset = 1'b0;
    run(HT * VT + 50);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
